// File: rtl/adc_multich_sequencer.sv
// Round-robin SPI ADC sequencer: picks the next enabled channel, runs one frame,
// decodes the returned channel ID and stores the offset-binary error per channel.
module adc_multich_sequencer #(
  parameter int N_CH        = 4,
  parameter int CH_BITS     = 2,
  parameter int DATA_W      = 16,
  parameter int M           = 12,
  parameter int M_LCD       = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 4
) (
  input  logic                     CLK20M,
  input  logic                     RSTp,
  input  logic                     EN,
  input  logic [N_CH-1:0]          CH_MASK,
  output logic                     SPI_START,
  output logic [CH_BITS-1:0]       CH_SEL,
  input  logic                     SPI_DONE,
  input  logic [DATA_W-1:0]        DATA_READ,
  output logic [N_CH*(M+1)-1:0]    ERR_DATA,
  output logic [N_CH*M_LCD-1:0]    LCD_DATA,
  output logic                     SAMPLE_VALID,
  output logic [CH_BITS-1:0]       SAMPLE_CH,
  output logic [N_CH-1:0]          NEW_FLAGS,
  input  logic [N_CH-1:0]          FLAG_CLR,
  output logic                     CH_MISMATCH,
  output logic                     TIMEOUT
);

  localparam int EW      = M + 1;
  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [CH_BITS-1:0]  ptr_q;
  logic                start_n, to_n, cap, cnt_clr;

  logic [N_CH-1:0]     mask_rot;
  logic [CH_BITS:0]    pick_off, pick_sum;
  logic [CH_BITS-1:0]  pick;

  logic [CH_BITS-1:0]  rd_id;
  logic [EW-1:0]       rd_raw, rd_ob;
  logic                id_ok;
  logic [N_CH-1:0]     set_vec;
  logic                unused_data;

  // Mask rotated so bit 0 is the channel right after the last pick.
  assign mask_rot = N_CH'({CH_MASK, CH_MASK} >> ({1'b0, ptr_q} + 1'b1));

  always_comb begin
    pick_off = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (pick_off == '0 && mask_rot[i]) pick_off = (CH_BITS+1)'(i + 1);
    end
    pick_sum = {1'b0, ptr_q} + pick_off;
    if (pick_sum >= (CH_BITS+1)'(N_CH)) pick_sum = pick_sum - (CH_BITS+1)'(N_CH);
  end

  assign pick = pick_sum[CH_BITS-1:0];

  assign rd_id       = DATA_READ[DATA_W-2 -: CH_BITS];
  assign rd_raw      = DATA_READ[DATA_W-2-CH_BITS -: EW];
  assign rd_ob       = {~rd_raw[M], rd_raw[M-1:0]};
  assign id_ok       = (32'(rd_id) < N_CH);
  assign unused_data = ^DATA_READ;

  always_comb begin
    set_vec = '0;
    for (int unsigned k = 0; k < N_CH; k++) set_vec[k] = cap && (32'(rd_id) == k);
  end

  always_comb begin
    state_n = state;
    start_n = 1'b0;
    to_n    = 1'b0;
    cap     = 1'b0;
    cnt_clr = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (EN && (|CH_MASK)) begin
          start_n = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // DONE takes priority over the timeout on the final wait cycle
        if (SPI_DONE) begin
          cap     = 1'b1;
          cnt_clr = 1'b1;
          state_n = S_GAP;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          to_n    = 1'b1;
          cnt_clr = 1'b1;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cnt_clr = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK20M) begin
    if (RSTp) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr_q     <= CH_BITS'(N_CH - 1);
      SPI_START <= 1'b0;
      CH_SEL    <= '0;
      TIMEOUT   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      SPI_START <= start_n;
      TIMEOUT   <= to_n;
      if (start_n) begin
        CH_SEL <= pick;
        ptr_q  <= pick;
      end
    end
  end

  always_ff @(posedge CLK20M) begin
    if (RSTp) begin
      ERR_DATA     <= '0;
      NEW_FLAGS    <= '0;
      SAMPLE_VALID <= 1'b0;
      SAMPLE_CH    <= '0;
      CH_MISMATCH  <= 1'b0;
    end else begin
      SAMPLE_VALID <= cap && id_ok;
      CH_MISMATCH  <= cap && (rd_id != CH_SEL);
      // Set is OR-ed after the clear so a same-cycle sample keeps its flag.
      NEW_FLAGS    <= (NEW_FLAGS & ~FLAG_CLR) | set_vec;
      if (cap && id_ok) SAMPLE_CH <= rd_id;
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (set_vec[k]) ERR_DATA[k*EW +: EW] <= rd_ob;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lcd
    assign LCD_DATA[k*M_LCD +: M_LCD] = ERR_DATA[k*EW + M -: M_LCD];
  end

endmodule

// File: tb/tb_adc_multich_sequencer.sv
// Bench for adc_multich_sequencer: scenario tasks driving an SPI responder and
// comparing against a channel-array reference model.
module tb_adc_multich_sequencer;

  localparam int N_CH = 4, CH_BITS = 2, DATA_W = 16, M = 12, M_LCD = 8;
  localparam int TIMEOUT_CYC = 64, GAP_CYC = 4;
  localparam int EW = M + 1;

  logic                  CLK20M = 1'b0;
  logic                  RSTp, EN, SPI_DONE;
  logic [N_CH-1:0]       CH_MASK, FLAG_CLR, NEW_FLAGS;
  logic [DATA_W-1:0]     DATA_READ;
  logic                  SPI_START, SAMPLE_VALID, CH_MISMATCH, TIMEOUT;
  logic [CH_BITS-1:0]    CH_SEL, SAMPLE_CH;
  logic [N_CH*EW-1:0]    ERR_DATA;
  logic [N_CH*M_LCD-1:0] LCD_DATA;

  adc_multich_sequencer #(
    .N_CH(N_CH), .CH_BITS(CH_BITS), .DATA_W(DATA_W), .M(M), .M_LCD(M_LCD),
    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .CLK20M(CLK20M), .RSTp(RSTp), .EN(EN), .CH_MASK(CH_MASK),
    .SPI_START(SPI_START), .CH_SEL(CH_SEL), .SPI_DONE(SPI_DONE), .DATA_READ(DATA_READ),
    .ERR_DATA(ERR_DATA), .LCD_DATA(LCD_DATA), .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_CH(SAMPLE_CH), .NEW_FLAGS(NEW_FLAGS), .FLAG_CLR(FLAG_CLR),
    .CH_MISMATCH(CH_MISMATCH), .TIMEOUT(TIMEOUT)
  );

  always #25 CLK20M = ~CLK20M;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge CLK20M) cyc <= cyc + 1;

  int              exp_err [N_CH];
  logic [N_CH-1:0] exp_flags;
  int              last_pick;

  function automatic int next_pick(input logic [N_CH-1:0] mask, input int last);
    for (int i = 1; i <= N_CH; i++) if (mask[(last + i) % N_CH]) return (last + i) % N_CH;
    return -1;
  endfunction

  function automatic int to_ob(input int raw);
    return (raw + (1 << M)) % (1 << EW);
  endfunction

  function automatic logic [N_CH*EW-1:0] pack_err();
    logic [N_CH*EW-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++) v[k*EW +: EW] = EW'(exp_err[k]);
    return v;
  endfunction

  function automatic logic [N_CH*M_LCD-1:0] pack_lcd();
    logic [N_CH*M_LCD-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++) v[k*M_LCD +: M_LCD] = M_LCD'(exp_err[k] >> (EW - M_LCD));
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] mk_word(input int id, input int raw);
    logic [DATA_W-1:0] w;
    w = DATA_W'($urandom());
    w[DATA_W-2 -: CH_BITS] = CH_BITS'(id);
    w[DATA_W-2-CH_BITS -: EW] = EW'(raw);
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK20M);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) exp_err[k] = 0;
    exp_flags = '0;
    last_pick = N_CH - 1;
  endtask

  task automatic do_reset();
    RSTp = 1'b1; EN = 1'b0; SPI_DONE = 1'b0; FLAG_CLR = '0; CH_MASK = '0;
    tick(); tick();
    RSTp = 1'b0;
    model_reset();
  endtask

  task automatic wait_start(output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (SPI_START === 1'b1) begin
        at = cyc; ok = 1'b1;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL spi_start_wait: no SPI_START within 300 cycles (got none, required one)");
  endtask

  // Bench is in the SPI_START cycle; answer after lat cycles and check the capture.
  task automatic serve(input int lat, input int id_in, input int raw,
                       input logic [N_CH-1:0] clr, input logic [N_CH-1:0] mask_wait);
    int sel, id;
    sel = next_pick(CH_MASK, last_pick);
    n_cmp++;
    if (CH_SEL !== CH_BITS'(sel)) begin
      n_err++; $display("FAIL ch_sel: got %0d required %0d", CH_SEL, sel);
    end
    last_pick = sel;
    CH_MASK = mask_wait;
    id = (id_in < 0) ? sel : id_in;
    repeat (lat) tick();
    n_cmp++;
    if (CH_SEL !== CH_BITS'(sel)) begin
      n_err++; $display("FAIL ch_sel_stable: got %0d required %0d", CH_SEL, sel);
    end
    SPI_DONE = 1'b1; DATA_READ = mk_word(id, raw); FLAG_CLR = clr;
    tick();
    SPI_DONE = 1'b0; FLAG_CLR = '0; DATA_READ = DATA_W'($urandom());
    exp_flags = exp_flags & ~clr;
    if (id < N_CH) begin
      exp_err[id] = to_ob(raw);
      exp_flags[id] = 1'b1;
    end
    n_cmp++;
    if (SAMPLE_VALID !== (id < N_CH)) begin
      n_err++; $display("FAIL sample_valid: got %b required %b", SAMPLE_VALID, (id < N_CH));
    end
    if (id < N_CH) begin
      n_cmp++;
      if (SAMPLE_CH !== CH_BITS'(id)) begin
        n_err++; $display("FAIL sample_ch: got %0d required %0d", SAMPLE_CH, id);
      end
    end
    n_cmp++;
    if (CH_MISMATCH !== (id != sel)) begin
      n_err++; $display("FAIL ch_mismatch: got %b required %b", CH_MISMATCH, (id != sel));
    end
    n_cmp++;
    if (TIMEOUT !== 1'b0 || SPI_START !== 1'b0) begin
      n_err++; $display("FAIL capture_pulses: TIMEOUT=%b SPI_START=%b required 0 0", TIMEOUT, SPI_START);
    end
    n_cmp++;
    if (ERR_DATA !== pack_err()) begin
      n_err++; $display("FAIL err_data: got %h required %h", ERR_DATA, pack_err());
    end
    n_cmp++;
    if (LCD_DATA !== pack_lcd()) begin
      n_err++; $display("FAIL lcd_data: got %h required %h", LCD_DATA, pack_lcd());
    end
    n_cmp++;
    if (NEW_FLAGS !== exp_flags) begin
      n_err++; $display("FAIL new_flags: got %b required %b", NEW_FLAGS, exp_flags);
    end
    tick();
    n_cmp++;
    if (SAMPLE_VALID !== 1'b0 || CH_MISMATCH !== 1'b0) begin
      n_err++; $display("FAIL pulse_width: SAMPLE_VALID=%b CH_MISMATCH=%b required 0 0", SAMPLE_VALID, CH_MISMATCH);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (SPI_START !== 1'b0 || CH_SEL !== '0 || TIMEOUT !== 1'b0 || CH_MISMATCH !== 1'b0) begin
      n_err++; $display("FAIL %s_ctrl: START=%b SEL=%0d TO=%b MM=%b required all 0", tag, SPI_START, CH_SEL, TIMEOUT, CH_MISMATCH);
    end
    n_cmp++;
    if (ERR_DATA !== '0 || LCD_DATA !== '0) begin
      n_err++; $display("FAIL %s_data: ERR=%h LCD=%h required 0", tag, ERR_DATA, LCD_DATA);
    end
    n_cmp++;
    if (SAMPLE_VALID !== 1'b0 || SAMPLE_CH !== '0 || NEW_FLAGS !== '0) begin
      n_err++; $display("FAIL %s_sample: SV=%b SCH=%0d FLAGS=%b required 0", tag, SAMPLE_VALID, SAMPLE_CH, NEW_FLAGS);
    end
  endtask

  task automatic test_reset();
    int s; bit ok;
    RSTp = 1'b1; EN = 1'b1; CH_MASK = '1; FLAG_CLR = '0;
    SPI_DONE = 1'b1; DATA_READ = DATA_W'($urandom());
    tick(); tick(); tick();
    check_all_zero("reset");
    SPI_DONE = 1'b0; RSTp = 1'b0;
    model_reset();
    wait_start(s, ok);
    if (!ok) return;
    serve(3, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int s, prev, prev_lat, lat; bit ok;
    do_reset();
    CH_MASK = 4'b1111; EN = 1'b1;
    prev = -1; prev_lat = 0;
    for (int i = 0; i < 5; i++) begin
      wait_start(s, ok);
      if (!ok) return;
      n_cmp++;
      if (CH_SEL !== CH_BITS'(order[i])) begin
        n_err++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, CH_SEL, order[i]);
      end
      if (prev >= 0) begin
        n_cmp++;
        if (s != prev + (prev_lat + 1) + 1 + GAP_CYC) begin
          n_err++; $display("FAIL rr_spacing: got %0d required %0d", s - prev, (prev_lat + 1) + 1 + GAP_CYC);
        end
      end
      lat = $urandom_range(0, 8);
      serve(lat, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
      prev = s; prev_lat = lat;
    end
  endtask

  task automatic test_mask();
    int order [4] = '{1, 3, 1, 3};
    int s; bit ok;
    do_reset();
    CH_MASK = 4'b1010; EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(s, ok);
      if (!ok) return;
      n_cmp++;
      if (CH_SEL !== CH_BITS'(order[i])) begin
        n_err++; $display("FAIL mask_order[%0d]: got %0d required %0d", i, CH_SEL, order[i]);
      end
      serve($urandom_range(0, 6), -1, $urandom_range(0, (1 << EW) - 1), '0,
            (i == 3) ? 4'b0100 : CH_MASK);
    end
    wait_start(s, ok);
    if (!ok) return;
    n_cmp++;
    if (CH_SEL !== 2'd2) begin
      n_err++; $display("FAIL mask_change: got %0d required 2", CH_SEL);
    end
    serve(2, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
  endtask

  task automatic test_conversion();
    int raws [3] = '{'h1000, 'h0FFF, 0};
    int obs  [3] = '{0, 'h1FFF, 'h1000};
    int lcds [3] = '{0, 'hFF, 'h80};
    int s; bit ok;
    do_reset();
    CH_MASK = 4'b0100; EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_start(s, ok);
      if (!ok) return;
      serve($urandom_range(0, 5), -1, raws[i], '0, CH_MASK);
      n_cmp++;
      if (ERR_DATA[2*EW +: EW] !== EW'(obs[i]) || LCD_DATA[2*M_LCD +: M_LCD] !== M_LCD'(lcds[i])) begin
        n_err++; $display("FAIL conv_ch2[%0d]: got %h/%h required %h/%h", i,
                          ERR_DATA[2*EW +: EW], LCD_DATA[2*M_LCD +: M_LCD], obs[i], lcds[i]);
      end
    end
  endtask

  task automatic test_mismatch();
    int s; bit ok;
    logic [EW-1:0] ch1_before;
    do_reset();
    CH_MASK = 4'b0010; EN = 1'b1;
    wait_start(s, ok);
    if (!ok) return;
    serve(1, -1, $urandom_range(1, (1 << EW) - 1), '0, CH_MASK);
    ch1_before = EW'(exp_err[1]);
    wait_start(s, ok);
    if (!ok) return;
    serve(4, 3, 'h0001, '0, CH_MASK);
    n_cmp++;
    if (ERR_DATA[3*EW +: EW] !== 13'h1001 || ERR_DATA[1*EW +: EW] !== ch1_before) begin
      n_err++; $display("FAIL mismatch_store: ch3=%h ch1=%h required 1001 %h",
                        ERR_DATA[3*EW +: EW], ERR_DATA[1*EW +: EW], ch1_before);
    end
  endtask

  task automatic test_timeout();
    int s, t_to, s2; bit ok;
    do_reset();
    CH_MASK = 4'b0001; EN = 1'b1;
    wait_start(s, ok);
    if (!ok) return;
    last_pick = next_pick(CH_MASK, last_pick);
    t_to = -1;
    for (int i = 0; i < TIMEOUT_CYC + 10; i++) begin
      tick();
      if (TIMEOUT === 1'b1) begin
        t_to = cyc;
        break;
      end
    end
    n_cmp++;
    if (t_to != s + TIMEOUT_CYC) begin
      n_err++; $display("FAIL timeout_cycle: got %0d required %0d", t_to - s, TIMEOUT_CYC);
    end
    if (t_to < 0) return;
    SPI_DONE = 1'b1; DATA_READ = mk_word(0, $urandom_range(1, (1 << EW) - 1));
    tick();
    SPI_DONE = 1'b0;
    n_cmp++;
    if (TIMEOUT !== 1'b0) begin
      n_err++; $display("FAIL timeout_pulse: got %b required 0", TIMEOUT);
    end
    n_cmp++;
    if (SAMPLE_VALID !== 1'b0 || ERR_DATA !== '0 || NEW_FLAGS !== '0) begin
      n_err++; $display("FAIL late_done: SV=%b ERR=%h FLAGS=%b required 0", SAMPLE_VALID, ERR_DATA, NEW_FLAGS);
    end
    wait_start(s2, ok);
    if (!ok) return;
    n_cmp++;
    if (s2 != t_to + GAP_CYC + 1) begin
      n_err++; $display("FAIL timeout_restart: got %0d required %0d", s2 - t_to, GAP_CYC + 1);
    end
    serve(TIMEOUT_CYC - 1, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
  endtask

  task automatic test_flag_clr();
    int s; bit ok;
    do_reset();
    CH_MASK = 4'b0011; EN = 1'b1;
    wait_start(s, ok); if (!ok) return;
    serve(2, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
    wait_start(s, ok); if (!ok) return;
    serve(2, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
    wait_start(s, ok); if (!ok) return;
    serve(2, -1, $urandom_range(0, (1 << EW) - 1), 4'b0011, CH_MASK);
    n_cmp++;
    if (NEW_FLAGS !== 4'b0001) begin
      n_err++; $display("FAIL flag_set_wins: got %b required 0001", NEW_FLAGS);
    end
    FLAG_CLR = 4'b0001;
    tick();
    FLAG_CLR = '0;
    exp_flags = exp_flags & ~4'b0001;
    n_cmp++;
    if (NEW_FLAGS !== exp_flags) begin
      n_err++; $display("FAIL flag_clear: got %b required %b", NEW_FLAGS, exp_flags);
    end
  endtask

  task automatic test_reset_midframe();
    int s; bit ok;
    do_reset();
    CH_MASK = 4'b1111; EN = 1'b1;
    wait_start(s, ok); if (!ok) return;
    serve(2, -1, $urandom_range(1, (1 << EW) - 1), '0, CH_MASK);
    wait_start(s, ok); if (!ok) return;
    tick();
    RSTp = 1'b1; EN = 1'b0;
    tick();
    RSTp = 1'b0;
    SPI_DONE = 1'b1; DATA_READ = mk_word(1, $urandom_range(1, (1 << EW) - 1));
    tick();
    SPI_DONE = 1'b0;
    check_all_zero("reset_midframe");
    model_reset();
    EN = 1'b1;
    wait_start(s, ok); if (!ok) return;
    serve(1, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
  endtask

  task automatic test_en_low();
    int s; bit ok, seen;
    do_reset();
    CH_MASK = 4'b1111; EN = 1'b1;
    wait_start(s, ok); if (!ok) return;
    EN = 1'b0;
    serve(5, -1, $urandom_range(0, (1 << EW) - 1), '0, CH_MASK);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (SPI_START === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL en_low_idle: SPI_START seen=%b required 0", seen);
    end
  endtask

  task automatic test_random();
    int s, prev, prev_lat, lat, id; bit ok;
    do_reset();
    EN = 1'b1;
    prev = -1; prev_lat = 0;
    for (int i = 0; i < 30; i++) begin
      CH_MASK = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      wait_start(s, ok);
      if (!ok) return;
      if (prev >= 0) begin
        n_cmp++;
        if (s != prev + (prev_lat + 1) + 1 + GAP_CYC) begin
          n_err++; $display("FAIL rand_spacing: got %0d required %0d", s - prev, (prev_lat + 1) + 1 + GAP_CYC);
        end
      end
      lat = $urandom_range(0, TIMEOUT_CYC - 1);
      id  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << CH_BITS) - 1)) : -1;
      serve(lat, id, $urandom_range(0, (1 << EW) - 1), N_CH'($urandom()), CH_MASK);
      prev = s; prev_lat = lat;
    end
  endtask

  initial begin
    RSTp = 1'b1; EN = 1'b0; CH_MASK = '0; FLAG_CLR = '0; SPI_DONE = 1'b0; DATA_READ = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_mask();
    test_conversion();
    test_mismatch();
    test_timeout();
    test_flag_clr();
    test_reset_midframe();
    test_en_low();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
